// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU width, op-select encodings and the priority
// decoder that turns the one-hot-ish enables into a single op code.
package cpu_pkg;

    localparam int ALU_W = 8;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_SUM  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_EOR  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_SR   = 3'd5;

    typedef struct packed {
        logic [ALU_W-1:0] res;
        logic             c;
        logic             v;
    } alu_out_t;

    // Enables are nominally one-hot; when several are high, SUM wins, then AND, EOR, OR, SR.
    function automatic logic [2:0] alu_decode(
        input logic sum_en,
        input logic and_en,
        input logic eor_en,
        input logic or_en,
        input logic sr_en
    );
        logic [2:0] op;
        if (sum_en)      op = OP_SUM;
        else if (and_en) op = OP_AND;
        else if (eor_en) op = OP_EOR;
        else if (or_en)  op = OP_OR;
        else if (sr_en)  op = OP_SR;
        else             op = OP_NONE;
        return op;
    endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/control/result bundle between the CPU control logic and the ALU.
interface alu_if;
    import cpu_pkg::*;

    logic             SUM_en;
    logic             AND_en;
    logic             EOR_en;
    logic             OR_en;
    logic             SR_en;
    logic             INV_en;
    logic [ALU_W-1:0] Ain;
    logic [ALU_W-1:0] Bin;
    logic             Cin;
    logic [ALU_W-1:0] RES;
    logic             Cout;
    logic             OVFout;

    modport master (
        output SUM_en, AND_en, EOR_en, OR_en, SR_en, INV_en, Ain, Bin, Cin,
        input  RES, Cout, OVFout
    );

    modport slave (
        input  SUM_en, AND_en, EOR_en, OR_en, SR_en, INV_en, Ain, Bin, Cin,
        output RES, Cout, OVFout
    );
endinterface

// File: rtl/alu_comb.sv
// Combinational ALU datapath: computes next result, carry and overflow for
// the decoded op. SBC is simply SUM with the B operand inverted.
module alu_comb
    import cpu_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [ALU_W-1:0] ain,
    input  logic [ALU_W-1:0] bin,
    input  logic             cin,
    input  logic             inv_en,
    output alu_out_t         nxt
);

    logic [ALU_W-1:0] b_eff;
    logic [ALU_W:0]   sum9;

    for (genvar gi = 0; gi < ALU_W; gi++) begin : g_inv
        assign b_eff[gi] = bin[gi] ^ inv_en;
    end

    assign sum9 = {1'b0, ain} + {1'b0, b_eff} + {{ALU_W{1'b0}}, cin};

    always_comb begin
        nxt = '0;
        case (op)
            OP_SUM: begin
                nxt.res = sum9[ALU_W-1:0];
                nxt.c   = sum9[ALU_W];
                // Like-signed operands producing an opposite-signed result.
                nxt.v   = (ain[ALU_W-1] == b_eff[ALU_W-1]) &&
                          (sum9[ALU_W-1] != ain[ALU_W-1]);
            end
            OP_AND: nxt.res = ain & b_eff;
            OP_EOR: nxt.res = ain ^ b_eff;
            OP_OR:  nxt.res = ain | b_eff;
            OP_SR: begin
                nxt.res = {cin, ain[ALU_W-1:1]};
                nxt.c   = ain[0];
            end
            default: nxt = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// 6502-style ALU top: decodes the enables, registers the datapath outputs,
// and holds them on cycles where no operation is selected.
module alu
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [2:0] op;
    alu_out_t   nxt;
    alu_out_t   out_reg;

    assign op = alu_decode(bus.SUM_en, bus.AND_en, bus.EOR_en, bus.OR_en, bus.SR_en);

    alu_comb u_comb (
        .op     (op),
        .ain    (bus.Ain),
        .bin    (bus.Bin),
        .cin    (bus.Cin),
        .inv_en (bus.INV_en),
        .nxt    (nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg <= '0;
        end else if (op != OP_NONE) begin
            out_reg <= nxt;
        end
    end

    assign bus.RES    = out_reg.res;
    assign bus.Cout   = out_reg.c;
    assign bus.OVFout = out_reg.v;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: stimulus pushes hand-computed expectations
// into a queue, a monitor pops one per cycle after the sampling edge.
module tb_alu;

    typedef struct {
        string      name;
        logic [7:0] res;
        logic       c;
        logic       v;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, checked 1ns after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (bus.RES !== e.res || bus.Cout !== e.c || bus.OVFout !== e.v) begin
                    errors++;
                    $display("FAIL %s: got RES=%h C=%b V=%b, want RES=%h C=%b V=%b",
                             e.name, bus.RES, bus.Cout, bus.OVFout, e.res, e.c, e.v);
                end else begin
                    $display("ok   %s: RES=%h C=%b V=%b", e.name, bus.RES, bus.Cout, bus.OVFout);
                end
            end
        end
    end

    // ops = {SUM, AND, EOR, OR, SR}
    task automatic issue(input string name, input logic r, input logic [4:0] ops,
                         input logic inv, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic [7:0] eres, input logic ec,
                         input logic ev);
        exp_t e;
        @(negedge clk);
        rst        = r;
        bus.SUM_en = ops[4];
        bus.AND_en = ops[3];
        bus.EOR_en = ops[2];
        bus.OR_en  = ops[1];
        bus.SR_en  = ops[0];
        bus.INV_en = inv;
        bus.Ain    = a;
        bus.Bin    = b;
        bus.Cin    = ci;
        e.name = name;
        e.res  = eres;
        e.c    = ec;
        e.v    = ev;
        exp_q.push_back(e);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.SUM_en = 1'b0; bus.AND_en = 1'b0; bus.EOR_en = 1'b0;
        bus.OR_en  = 1'b0; bus.SR_en  = 1'b0; bus.INV_en = 1'b0;
        bus.Ain = 8'h00; bus.Bin = 8'h00; bus.Cin = 1'b0;

        //     name         rst  SAEOS     inv  A      B      Cin   RES    C     V
        issue("reset0",     1'b1, 5'b10000, 1'b0, 8'h55, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        issue("reset1",     1'b1, 5'b10000, 1'b0, 8'h55, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        issue("add_wrap",   1'b0, 5'b10000, 1'b0, 8'h09, 8'hFF, 1'b0, 8'h08, 1'b1, 1'b0);
        issue("add_ovf",    1'b0, 5'b10000, 1'b0, 8'h50, 8'h50, 1'b0, 8'hA0, 1'b0, 1'b1);
        issue("sub_borrow", 1'b0, 5'b10000, 1'b1, 8'h50, 8'hF0, 1'b1, 8'h60, 1'b0, 1'b0);
        issue("sub_ovf",    1'b0, 5'b10000, 1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        issue("ff_plus_1",  1'b0, 5'b10000, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        issue("and",        1'b0, 5'b01000, 1'b0, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0);
        issue("eor",        1'b0, 5'b00100, 1'b0, 8'hF0, 8'h3C, 1'b1, 8'hCC, 1'b0, 1'b0);
        issue("or",         1'b0, 5'b00010, 1'b0, 8'hF0, 8'h3C, 1'b1, 8'hFC, 1'b0, 1'b0);
        issue("and_inv",    1'b0, 5'b01000, 1'b1, 8'hF0, 8'h3C, 1'b0, 8'hC0, 1'b0, 1'b0);
        issue("sr",         1'b0, 5'b00001, 1'b1, 8'h81, 8'h5A, 1'b1, 8'hC0, 1'b1, 1'b0);
        issue("sr_cin0",    1'b0, 5'b00001, 1'b0, 8'h02, 8'hFF, 1'b0, 8'h01, 1'b0, 1'b0);
        issue("prio_sum",   1'b0, 5'b11000, 1'b0, 8'hF0, 8'h3C, 1'b0, 8'h2C, 1'b1, 1'b0);
        issue("prio_eor",   1'b0, 5'b00111, 1'b0, 8'hF0, 8'h3C, 1'b1, 8'hCC, 1'b0, 1'b0);
        issue("prio_and",   1'b0, 5'b01111, 1'b0, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0);
        issue("load_hold",  1'b0, 5'b10000, 1'b0, 8'hF0, 8'h3C, 1'b0, 8'h2C, 1'b1, 1'b0);
        issue("idle0",      1'b0, 5'b00000, 1'b1, 8'h55, 8'hAA, 1'b1, 8'h2C, 1'b1, 1'b0);
        issue("idle1",      1'b0, 5'b00000, 1'b0, 8'h00, 8'h00, 1'b0, 8'h2C, 1'b1, 1'b0);
        issue("idle2",      1'b0, 5'b00000, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'h2C, 1'b1, 1'b0);
        issue("reset_mid",  1'b1, 5'b01000, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        bus.SUM_en = 1'b0; bus.AND_en = 1'b0; bus.EOR_en = 1'b0;
        bus.OR_en  = 1'b0; bus.SR_en  = 1'b0;

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
